rtc_time_sequencer: RTL and testbench
=====================================

Name: rtc_time_sequencer

Overview:
- Upstream/downstream companion of the RTC bus protocol engine.
- Decides which RTC register each bus transaction targets, and whether it is a read or a write.
- Drives the engine's address, write-data and read/write-select inputs; captures the byte the engine returns after each read.
- Continuously polls six BCD time registers into a shadow register file for the VGA text layer, and converts user inc/dec pulses into BCD-correct single-register write transactions.

Parameters:
- ADDR_SEC, 8'h21, RTC address of seconds.
- ADDR_MIN, 8'h22, RTC address of minutes.
- ADDR_HOUR, 8'h23, RTC address of hours.
- ADDR_DATE, 8'h24, RTC address of day-of-month.
- ADDR_MONTH, 8'h25, RTC address of month.
- ADDR_YEAR, 8'h26, RTC address of year.
- INIT_ADDR, 8'h02, control register written at start-up (optional feature only).
- INIT_VALUE, 8'h10, value written to INIT_ADDR.

Ports:
- clk  in  1  100 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- contador_todo  in  7  free-running transaction phase counter from the protocol engine.
- data_vga  in  8  byte returned by the engine; stable from the transaction boundary onward.
- edit_sel  in  3  field to edit: 0 sec, 1 min, 2 hour, 3 date, 4 month, 5 year; 6 and 7 mean none.
- inc_pulse  in  1  one-cycle request to increment the selected field.
- dec_pulse  in  1  one-cycle request to decrement the selected field.
- address  out  8  RTC register address for the current transaction.
- data_write  out  8  BCD byte for the current write transaction.
- indicador_maquina  out  1  1 = read transaction, 0 = write transaction.
- sec, min, hour, date, month, year  out  8 each  BCD shadow registers.
- write_busy  out  1  high from an accepted edit until its write transaction has completed.
- sweep_tick  out  1  one-cycle pulse when all six fields have been refreshed.

Behaviour:
- Boundary (internal): the cycle where contador_todo == 0 and its registered previous value != 0. This is the only cycle in which address, data_write or indicador_maquina may change.
- Reset values:
  - sec, min, hour, date, month, year, data_write: 8'h00.
  - address: ADDR_SEC; indicador_maquina: 1; poll index: 0.
  - write_busy, sweep_tick: 0; previous-counter register: 0.
  - State: POLL, or INIT when RTC_INIT_EN is defined.
- POLL, at each boundary:
  - Store data_vga into the field selected by the poll index.
  - Advance the index modulo 6 and drive the corresponding address.
  - When the index wraps 5->0, pulse sweep_tick for that cycle.
  - If a write is pending, do not advance: go to WRITE (see WRITE_PEND).
- Edit acceptance:
  - Accepted only in POLL, with write_busy == 0, edit_sel <= 5, and exactly one of inc_pulse/dec_pulse high.
  - Both pulses high together, or either pulse while busy, is ignored (no queueing).
  - On acceptance: compute the new BCD value from the shadow field, update the shadow field in the same cycle, latch the value and the field's address, set write_busy, and go to WRITE_PEND.
- WRITE_PEND, at the next boundary:
  - Still store data_vga into the field just read, unless that field is the one being edited; the shadow edit wins.
  - Drive address = edit address, data_write = new value, indicador_maquina = 0; go to WRITE.
- WRITE, at the next boundary:
  - Clear write_busy and set indicador_maquina = 1.
  - Resume POLL at the index following the last polled field.
- BCD arithmetic (8-bit packed BCD):
  - Ranges: sec/min 00..59, hour 00..23, date 01..31, month 01..12, year 00..99.
  - Increment at max wraps to min; decrement at min wraps to max.
  - Nibble carry/borrow is handled correctly: 09+1 = 10, 10-1 = 09.
  - An illegal source value (nibble > 9 or out of range) is treated as the field minimum before the increment or decrement.
- Reset mid-transaction: all outputs return to reset values immediately. The first boundary seen after reset release starts normal operation; a partially observed transaction is never captured.
- The count of cycles between boundaries is set by the protocol engine; the block must not assume any fixed period.

Optional Feature:
- Macro: RTC_INIT_EN.
- Defined: after reset the state is INIT. Drive address = INIT_ADDR, data_write = INIT_VALUE, indicador_maquina = 0, write_busy = 1. At the first boundary switch to POLL at index 0 with address = ADDR_SEC, indicador_maquina = 1, write_busy = 0. Edits are ignored during INIT.
- Not defined: the block starts directly in POLL; INIT_ADDR and INIT_VALUE are unused.

Test Plan:
- Reset, then run the counter 0..74 repeatedly while data_vga returns 8'h45,8'h30,8'h12,8'h07,8'h11,8'h24 on successive boundaries -> sec=45, min=30, hour=12, date=07, month=11, year=24; sweep_tick pulses once per 6 boundaries; address cycles 21..26.
- sec=8'h59, edit_sel=0, inc_pulse -> sec=8'h00 immediately, write_busy=1; next boundary address=21, data_write=00, indicador_maquina=0; following boundary write_busy=0, indicador_maquina=1.
- month=8'h01 dec -> 8'h12; hour=8'h23 inc -> 8'h00; date=8'h09 inc -> 8'h10; year=8'h00 dec -> 8'h99.
- inc_pulse and dec_pulse high in the same cycle, or inc_pulse while write_busy=1 -> no field change, no extra write.
- Assert reset_n low while counter=40 in a WRITE transaction -> all outputs at reset values the same cycle; after release the first capture occurs only at a genuine boundary.
- With RTC_INIT_EN: after reset address=02, data_write=10, indicador_maquina=0 until the first boundary, then polling from address 21.

Source files
------------

// File: rtl/rtc_time_sequencer_if.sv
// Bus between rtc_time_sequencer (master) and the RTC protocol engine (slave):
// transaction phase counter, returned read byte, and the address/data/direction the engine executes.
interface rtc_time_sequencer_if;
    logic [6:0] contador_todo;
    logic [7:0] data_vga;
    logic [7:0] address;
    logic [7:0] data_write;
    logic       indicador_maquina;

    modport master (
        input  contador_todo,
        input  data_vga,
        output address,
        output data_write,
        output indicador_maquina
    );

    modport slave (
        output contador_todo,
        output data_vga,
        input  address,
        input  data_write,
        input  indicador_maquina
    );
endinterface

// File: rtl/rtc_time_sequencer.sv
// Polls six BCD RTC time registers into shadow copies and turns inc/dec pulses into
// single-register BCD write transactions. Define RTC_INIT_EN for a start-up control-register write.
module rtc_time_sequencer #(
    parameter logic [7:0] ADDR_SEC   = 8'h21,
    parameter logic [7:0] ADDR_MIN   = 8'h22,
    parameter logic [7:0] ADDR_HOUR  = 8'h23,
    parameter logic [7:0] ADDR_DATE  = 8'h24,
    parameter logic [7:0] ADDR_MONTH = 8'h25,
    parameter logic [7:0] ADDR_YEAR  = 8'h26
`ifdef RTC_INIT_EN
    ,
    parameter logic [7:0] INIT_ADDR  = 8'h02,
    parameter logic [7:0] INIT_VALUE = 8'h10
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rtc_time_sequencer_if.master bus,
    input  logic [2:0]           edit_sel,
    input  logic                 inc_pulse,
    input  logic                 dec_pulse,
    output logic [7:0]           sec,
    output logic [7:0]           min,
    output logic [7:0]           hour,
    output logic [7:0]           date,
    output logic [7:0]           month,
    output logic [7:0]           year,
    output logic                 write_busy,
    output logic                 sweep_tick
);

    typedef enum logic [1:0] {INIT, POLL, WRITE_PEND, WRITE} state_t;

`ifdef RTC_INIT_EN
    localparam state_t     RST_STATE = INIT;
    localparam logic [7:0] RST_ADDR  = INIT_ADDR;
    localparam logic [7:0] RST_DATA  = INIT_VALUE;
    localparam logic       RST_RD    = 1'b0;
    localparam logic       RST_BUSY  = 1'b1;
`else
    localparam state_t     RST_STATE = POLL;
    localparam logic [7:0] RST_ADDR  = ADDR_SEC;
    localparam logic [7:0] RST_DATA  = 8'h00;
    localparam logic       RST_RD    = 1'b1;
    localparam logic       RST_BUSY  = 1'b0;
`endif

    function automatic logic [7:0] field_addr(input logic [2:0] i);
        case (i)
            3'd0:    return ADDR_SEC;
            3'd1:    return ADDR_MIN;
            3'd2:    return ADDR_HOUR;
            3'd3:    return ADDR_DATE;
            3'd4:    return ADDR_MONTH;
            default: return ADDR_YEAR;
        endcase
    endfunction

    function automatic logic [7:0] field_lo(input logic [2:0] i);
        return (i == 3'd3 || i == 3'd4) ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [7:0] field_hi(input logic [2:0] i);
        case (i)
            3'd0, 3'd1: return 8'h59;
            3'd2:       return 8'h23;
            3'd3:       return 8'h31;
            3'd4:       return 8'h12;
            default:    return 8'h99;
        endcase
    endfunction

    // Packed BCD compares correctly as binary once both nibbles are decimal digits.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic up);
        logic [7:0] s;
        s = (v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v >= lo && v <= hi) ? v : lo;
        if (up) begin
            if (s == hi)            return lo;
            else if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
            else                     return s + 8'd1;
        end else begin
            if (s == lo)            return hi;
            else if (s[3:0] == 4'd0) return {s[7:4] - 4'd1, 4'd9};
            else                     return s - 8'd1;
        end
    endfunction

    state_t     state_q, state_n;
    logic [2:0] idx_q, idx_n, nxt_idx;
    logic [7:0] field_q [0:5];
    logic [7:0] field_n [0:5];
    logic [7:0] address_q, address_n, data_write_q, data_write_n;
    logic       rd_q, rd_n, busy_q, busy_n, tick_q, tick_n;
    logic [2:0] edit_idx_q, edit_idx_n;
    logic [7:0] edit_val_q, edit_val_n, sel_val, new_val;
    logic [6:0] cnt_p1;
    logic       synced_q;
    logic       act, edit_ok;

    // A boundary only acts once a whole transaction has been observed since reset.
    assign act     = (bus.contador_todo == 7'd0) && (cnt_p1 != 7'd0) && synced_q;
    assign edit_ok = (state_q == POLL) && !busy_q && (edit_sel <= 3'd5) && (inc_pulse ^ dec_pulse);
    assign nxt_idx = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    always_comb begin
        sel_val = 8'h00;
        for (int i = 0; i < 6; i++)
            if (edit_sel == 3'(i)) sel_val = field_q[i];
        new_val = bcd_step(sel_val, field_lo(edit_sel), field_hi(edit_sel), inc_pulse);
    end

    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        address_n    = address_q;
        data_write_n = data_write_q;
        rd_n         = rd_q;
        busy_n       = busy_q;
        tick_n       = 1'b0;
        edit_idx_n   = edit_idx_q;
        edit_val_n   = edit_val_q;
        for (int i = 0; i < 6; i++) field_n[i] = field_q[i];

        case (state_q)
            INIT: if (act) begin
                state_n   = POLL;
                idx_n     = 3'd0;
                address_n = field_addr(3'd0);
                rd_n      = 1'b1;
                busy_n    = 1'b0;
            end
            POLL: begin
                if (act) begin
                    for (int i = 0; i < 6; i++)
                        if (idx_q == 3'(i)) field_n[i] = bus.data_vga;
                    idx_n     = nxt_idx;
                    address_n = field_addr(nxt_idx);
                    tick_n    = (idx_q == 3'd5);
                end
                // Applied after the capture so a same-cycle edit wins.
                if (edit_ok) begin
                    for (int i = 0; i < 6; i++)
                        if (edit_sel == 3'(i)) field_n[i] = new_val;
                    edit_idx_n = edit_sel;
                    edit_val_n = new_val;
                    busy_n     = 1'b1;
                    state_n    = WRITE_PEND;
                end
            end
            WRITE_PEND: if (act) begin
                for (int i = 0; i < 6; i++)
                    if (idx_q == 3'(i) && idx_q != edit_idx_q) field_n[i] = bus.data_vga;
                idx_n        = nxt_idx;
                tick_n       = (idx_q == 3'd5);
                address_n    = field_addr(edit_idx_q);
                data_write_n = edit_val_q;
                rd_n         = 1'b0;
                state_n      = WRITE;
            end
            WRITE: if (act) begin
                busy_n    = 1'b0;
                rd_n      = 1'b1;
                address_n = field_addr(idx_q);
                state_n   = POLL;
            end
            default: state_n = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RST_STATE;
            idx_q        <= 3'd0;
            address_q    <= RST_ADDR;
            data_write_q <= RST_DATA;
            rd_q         <= RST_RD;
            busy_q       <= RST_BUSY;
            tick_q       <= 1'b0;
            edit_idx_q   <= 3'd0;
            edit_val_q   <= 8'h00;
            cnt_p1       <= 7'd0;
            synced_q     <= 1'b0;
            for (int i = 0; i < 6; i++) field_q[i] <= 8'h00;
        end else begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            address_q    <= address_n;
            data_write_q <= data_write_n;
            rd_q         <= rd_n;
            busy_q       <= busy_n;
            tick_q       <= tick_n;
            edit_idx_q   <= edit_idx_n;
            edit_val_q   <= edit_val_n;
            cnt_p1       <= bus.contador_todo;
            synced_q     <= synced_q | (bus.contador_todo == 7'd0);
            for (int i = 0; i < 6; i++) field_q[i] <= field_n[i];
        end
    end

    assign bus.address           = address_q;
    assign bus.data_write        = data_write_q;
    assign bus.indicador_maquina = rd_q;
    assign sec        = field_q[0];
    assign min        = field_q[1];
    assign hour       = field_q[2];
    assign date       = field_q[3];
    assign month      = field_q[4];
    assign year       = field_q[5];
    assign write_busy = busy_q;
    assign sweep_tick = tick_q;

endmodule

// File: tb/tb_rtc_time_sequencer.sv
// Directed bench for rtc_time_sequencer: polling sweep, BCD edits, ignored edits and
// reset during a write. Honours RTC_INIT_EN for the start-up write.
module tb_rtc_time_sequencer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] edit_sel = 3'd7;
    logic       inc_pulse = 1'b0;
    logic       dec_pulse = 1'b0;
    logic [7:0] sec, min, hour, date, month, year;
    logic       write_busy, sweep_tick;
    int         n_checks = 0;
    int         n_errors = 0;

    rtc_time_sequencer_if bus ();

    rtc_time_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .edit_sel   (edit_sel),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .date       (date),
        .month      (month),
        .year       (year),
        .write_busy (write_busy),
        .sweep_tick (sweep_tick)
    );

    always #5 clk = ~clk;

`ifdef RTC_INIT_EN
    localparam logic [7:0] RST_ADDR = 8'h02, RST_DATA = 8'h10;
    localparam logic       RST_RD = 1'b0, RST_BUSY = 1'b1;
`else
    localparam logic [7:0] RST_ADDR = 8'h21, RST_DATA = 8'h00;
    localparam logic       RST_RD = 1'b1, RST_BUSY = 1'b0;
`endif

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fld(input int s);
        case (s)
            0:       return sec;
            1:       return min;
            2:       return hour;
            3:       return date;
            4:       return month;
            default: return year;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: counter 1..74, then the boundary cycle with the returned byte.
    task automatic run_txn(input logic [7:0] rd);
        for (int c = 1; c < 75; c++) begin
            bus.contador_todo = 7'(c);
            step();
        end
        bus.contador_todo = 7'd0;
        bus.data_vga      = rd;
        step();
    endtask

    task automatic pulse(input logic [2:0] s, input logic i, input logic d);
        edit_sel  = s;
        inc_pulse = i;
        dec_pulse = d;
        step();
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        edit_sel  = 3'd7;
    endtask

    task automatic check_reset();
        for (int s = 0; s < 6; s++) chk($sformatf("rst_field%0d", s), fld(s), 8'h00);
        chk("rst_addr", bus.address, RST_ADDR);
        chk("rst_wdata", bus.data_write, RST_DATA);
        chk("rst_rdsel", {7'd0, bus.indicador_maquina}, {7'd0, RST_RD});
        chk("rst_busy", {7'd0, write_busy}, {7'd0, RST_BUSY});
        chk("rst_tick", {7'd0, sweep_tick}, 8'h00);
    endtask

    task automatic do_edit(input int s, input logic up, input logic [7:0] exp_val,
                           input logic [7:0] rd, input logic [7:0] resume);
        pulse(3'(s), up, !up);
        chk("edit_val", fld(s), exp_val);
        chk("edit_busy", {7'd0, write_busy}, 8'h01);
        run_txn(rd);
        chk("wr_addr", bus.address, 8'(8'h21 + s));
        chk("wr_data", bus.data_write, exp_val);
        chk("wr_rdsel", {7'd0, bus.indicador_maquina}, 8'h00);
        chk("edit_keep", fld(s), exp_val);
        run_txn(8'hEE);
        chk("wr_done", {7'd0, write_busy}, 8'h00);
        chk("rd_rdsel", {7'd0, bus.indicador_maquina}, 8'h01);
        chk("resume_addr", bus.address, resume);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] sweep1 [6];
        logic [7:0] sweep2 [6];
        sweep1 = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h11, 8'h24};
        sweep2 = '{8'h59, 8'h30, 8'h23, 8'h09, 8'h01, 8'h00};
        bus.contador_todo = 7'd0;
        bus.data_vga      = 8'h00;
        repeat (3) step();
        check_reset();
        reset_n = 1'b1;
        step();
`ifdef RTC_INIT_EN
        chk("init_hold_addr", bus.address, 8'h02);
        run_txn(8'h00);
        chk("init_exit_addr", bus.address, 8'h21);
        chk("init_exit_rdsel", {7'd0, bus.indicador_maquina}, 8'h01);
        chk("init_exit_busy", {7'd0, write_busy}, 8'h00);
`endif

        // Polling sweep: address walks 21..26 and wraps with one sweep_tick.
        for (int k = 1; k <= 6; k++) begin
            run_txn(sweep1[k-1]);
            chk("poll_addr", bus.address, 8'(8'h21 + (k % 6)));
            chk("poll_tick", {7'd0, sweep_tick}, (k == 6) ? 8'h01 : 8'h00);
        end
        for (int s = 0; s < 6; s++) chk($sformatf("sweep_field%0d", s), fld(s), sweep1[s]);
        step();
        chk("tick_one_cycle", {7'd0, sweep_tick}, 8'h00);
        for (int k = 0; k < 6; k++) run_txn(sweep2[k]);

        // Edits, with wrap, nibble carry/borrow and the shadow edit winning over a read.
        do_edit(0, 1'b1, 8'h00, 8'h58, 8'h22);
        do_edit(4, 1'b0, 8'h12, 8'h30, 8'h23);
        do_edit(2, 1'b1, 8'h00, 8'h77, 8'h24);
        do_edit(3, 1'b1, 8'h10, 8'h55, 8'h25);
        do_edit(5, 1'b0, 8'h99, 8'h12, 8'h26);
        do_edit(3, 1'b0, 8'h09, 8'h99, 8'h21);
        chk("min_captured", min, 8'h30);
        chk("month_captured", month, 8'h12);
        chk("year_captured", year, 8'h99);

        // Illegal source value is treated as the field minimum.
        run_txn(8'h00);
        run_txn(8'h7A);
        chk("illegal_min", min, 8'h7A);
        do_edit(1, 1'b1, 8'h01, 8'h00, 8'h24);

        // Ignored edits: both pulses, out-of-range field, pulses while busy.
        pulse(3'd1, 1'b1, 1'b1);
        chk("both_pulses_min", min, 8'h01);
        chk("both_pulses_busy", {7'd0, write_busy}, 8'h00);
        pulse(3'd6, 1'b1, 1'b0);
        chk("sel6_busy", {7'd0, write_busy}, 8'h00);
        pulse(3'd0, 1'b1, 1'b0);
        chk("busy_edit_sec", sec, 8'h01);
        pulse(3'd0, 1'b1, 1'b0);
        pulse(3'd0, 1'b0, 1'b1);
        chk("busy_ignore_sec", sec, 8'h01);
        run_txn(8'h09);
        chk("busy_wr_data", bus.data_write, 8'h01);
        chk("busy_wr_addr", bus.address, 8'h21);
        run_txn(8'hEE);
        chk("busy_resume", bus.address, 8'h25);
        run_txn(8'h12);
        chk("no_extra_write", {7'd0, bus.indicador_maquina}, 8'h01);
        chk("no_extra_addr", bus.address, 8'h26);
        chk("no_extra_busy", {7'd0, write_busy}, 8'h00);

        // Reset asserted at counter 40 of a write transaction.
        pulse(3'd0, 1'b1, 1'b0);
        chk("pre_rst_sec", sec, 8'h02);
        run_txn(8'h99);
        chk("pre_rst_rdsel", {7'd0, bus.indicador_maquina}, 8'h00);
        for (int c = 1; c <= 40; c++) begin
            bus.contador_todo = 7'(c);
            step();
        end
        reset_n = 1'b0;
        #1;
        check_reset();
        for (int c = 41; c < 75; c++) begin
            bus.contador_todo = 7'(c);
            step();
        end
        bus.contador_todo = 7'd0;
        bus.data_vga      = 8'h33;
        reset_n           = 1'b1;
        step();
        chk("no_false_capture", sec, 8'h00);
        chk("no_false_addr", bus.address, RST_ADDR);
`ifdef RTC_INIT_EN
        run_txn(8'h00);
`endif
        run_txn(8'h44);
        chk("post_rst_sec", sec, 8'h44);
        chk("post_rst_addr", bus.address, 8'h22);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
